// File: rtl/index_sequencer_if.sv
// index_sequencer_if: start/abort command, burst parameters, index handshake and status
// between the controlling logic, the sequencer and the downstream lookup stage.
interface index_sequencer_if #(
    parameter int LOG2_WIDTH = 3
);
    logic                  start;
    logic                  abort;
    logic [LOG2_WIDTH:0]   base;
    logic [LOG2_WIDTH:0]   step;
    logic [LOG2_WIDTH:0]   length;
    logic                  ready;
    logic [LOG2_WIDTH:0]   index;
    logic                  valid;
    logic                  busy;
    logic                  done;
    logic                  aborted;
    logic [LOG2_WIDTH:0]   count;

    modport slave (
        input  start, abort, base, step, length, ready,
        output index, valid, busy, done, aborted, count
    );

    modport master (
        output start, abort, base, step, length, ready,
        input  index, valid, busy, done, aborted, count
    );
endinterface

// File: rtl/index_sequencer.sv
// index_sequencer: issues a burst of table indices base, base+step, ... modulo WIDTH
// over valid/ready, with done pulse, abort status and handshake count.
module index_sequencer #(
    parameter int LOG2_WIDTH = 3,
    parameter int WIDTH      = 2 ** LOG2_WIDTH
) (
    input  logic              clock,
    input  logic              reset,
    index_sequencer_if.slave  bus
);
    localparam int W = LOG2_WIDTH + 1;
    localparam logic [LOG2_WIDTH:0] mask = W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state_q;
    logic [LOG2_WIDTH:0] index_q, step_q, len_q, count_q;
    logic [LOG2_WIDTH:0] index_d, count_d;
    logic                valid_q, busy_q, done_q, aborted_q;
    logic                hs, last;

    always_comb begin
        hs      = valid_q & bus.ready;
        count_d = count_q + 1'b1;
        index_d = (index_q + step_q) & mask;
        last    = hs && (count_d == len_q);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            index_q   <= '0;
            step_q    <= '0;
            len_q     <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        index_q   <= bus.base & mask;
                        step_q    <= bus.step & mask;
                        len_q     <= bus.length;
                        count_q   <= '0;
                        aborted_q <= 1'b0;
                        busy_q    <= 1'b1;
                        valid_q   <= bus.length != '0;
                        done_q    <= bus.length == '0;
                        state_q   <= (bus.length != '0) ? RUN : DONE;
                    end
                end
                RUN: begin
                    if (hs) begin
                        count_q <= count_d;
                        index_q <= index_d;
                    end
                    // a final handshake outranks a coincident abort
                    if (last || bus.abort) begin
                        valid_q   <= 1'b0;
                        done_q    <= 1'b1;
                        aborted_q <= !last;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.index   = index_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
    assign bus.count   = count_q;
endmodule

// File: tb/tb_index_sequencer.sv
// tb_index_sequencer: directed bursts with hand-computed index sequences and status.
module tb_index_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad   = 0;
    int   exp_seq[8];

    index_sequencer_if #(.LOG2_WIDTH(3)) bus ();

    index_sequencer #(.LOG2_WIDTH(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_burst(input int b, input int s, input int l);
        bus.base   = 4'(b);
        bus.step   = 4'(s);
        bus.length = 4'(l);
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic run_seq(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            check({tag, "_idx"}, 32'(bus.index), 32'(exp_seq[i]));
            check({tag, "_vld"}, 32'(bus.valid), 1);
            tick();
        end
        check({tag, "_done"}, 32'(bus.done), 1);
        check({tag, "_vld_end"}, 32'(bus.valid), 0);
        check({tag, "_cnt"}, 32'(bus.count), 32'(n));
        check({tag, "_abt"}, 32'(bus.aborted), 0);
        check({tag, "_busy"}, 32'(bus.busy), 1);
        tick();
        check({tag, "_idle_busy"}, 32'(bus.busy), 0);
        check({tag, "_idle_done"}, 32'(bus.done), 0);
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.ready = 1'b1;
        bus.base = '0; bus.step = '0; bus.length = '0;
        tick(); tick();
        check("rst_idx", 32'(bus.index), 0);
        check("rst_vld", 32'(bus.valid), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_abt", 32'(bus.aborted), 0);
        check("rst_cnt", 32'(bus.count), 0);
        reset = 1'b0;
        tick();

        exp_seq = '{2, 3, 4, 5, 0, 0, 0, 0};
        start_burst(2, 1, 4);
        run_seq("basic", 4);

        exp_seq = '{6, 1, 4, 7, 0, 0, 0, 0};
        start_burst(6, 3, 4);
        run_seq("wrap", 4);

        exp_seq = '{1, 3, 5, 0, 0, 0, 0, 0};
        start_burst(9, 10, 3);
        run_seq("modlatch", 3);

        exp_seq = '{7, 7, 7, 0, 0, 0, 0, 0};
        start_burst(7, 8, 3);
        run_seq("step0", 3);

        // stall: ready low in cycles 2-3
        start_burst(2, 1, 4);
        check("stall_c1", 32'(bus.index), 2);
        tick();
        bus.ready = 1'b0;
        check("stall_c2", 32'(bus.index), 3);
        tick();
        check("stall_c3", 32'(bus.index), 3);
        check("stall_c3v", 32'(bus.valid), 1);
        tick();
        bus.ready = 1'b1;
        check("stall_c4", 32'(bus.index), 3);
        check("stall_c4v", 32'(bus.valid), 1);
        tick();
        check("stall_c5", 32'(bus.index), 4);
        tick();
        check("stall_c6", 32'(bus.index), 5);
        check("stall_c6cnt", 32'(bus.count), 3);
        tick();
        check("stall_c7done", 32'(bus.done), 1);
        check("stall_c7cnt", 32'(bus.count), 4);
        tick();

        start_burst(3, 1, 0);
        check("zero_vld", 32'(bus.valid), 0);
        check("zero_done", 32'(bus.done), 1);
        check("zero_busy", 32'(bus.busy), 1);
        check("zero_cnt", 32'(bus.count), 0);
        tick();
        check("zero_busy2", 32'(bus.busy), 0);
        check("zero_done2", 32'(bus.done), 0);
        tick();

        start_burst(0, 1, 5);
        tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_cnt", 32'(bus.count), 2);
        check("abort_vld", 32'(bus.valid), 0);
        check("abort_done", 32'(bus.done), 1);
        check("abort_flag", 32'(bus.aborted), 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort_hold", 32'(bus.aborted), 1);
        check("abort_idle", 32'(bus.busy), 0);
        tick();

        start_burst(0, 1, 5);
        check("abort5_clr", 32'(bus.aborted), 0);
        repeat (4) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("abort5_cnt", 32'(bus.count), 5);
        check("abort5_done", 32'(bus.done), 1);
        check("abort5_flag", 32'(bus.aborted), 0);
        tick(); tick();

        start_burst(2, 1, 4);
        tick();
        bus.base = 4'd7; bus.length = 4'd1; bus.start = 1'b1;
        check("ign_c2", 32'(bus.index), 3);
        tick();
        check("ign_c3", 32'(bus.index), 4);
        tick();
        bus.start = 1'b0;
        check("ign_c4", 32'(bus.index), 5);
        tick();
        check("ign_done", 32'(bus.done), 1);
        check("ign_cnt", 32'(bus.count), 4);
        tick(); tick();

        start_burst(1, 2, 6);
        tick(); tick();
        reset = 1'b1;
        #1;
        check("mid_rst_vld", 32'(bus.valid), 0);
        check("mid_rst_busy", 32'(bus.busy), 0);
        check("mid_rst_idx", 32'(bus.index), 0);
        check("mid_rst_cnt", 32'(bus.count), 0);
        tick();
        check("mid_rst_done", 32'(bus.done), 0);
        reset = 1'b0;
        tick();

        exp_seq = '{5, 6, 0, 0, 0, 0, 0, 0};
        start_burst(5, 1, 2);
        run_seq("restart", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
